// File: rtl/spi_peripheral_if.sv
// ---------------------------------------------------------------------------
// spi_peripheral_if
// Parallel-side bus of the SPI peripheral: the transmit word handshake and
// the received word / status pulses.
//
// Signals
//   i_tx_data     [WIDTH]  word the user wants to send next
//   i_tx_valid             i_tx_data is valid
//   o_tx_ready             holding register empty, word can be accepted
//   o_rx_data     [WIDTH]  last word received from the controller
//   o_rx_valid             one-cycle pulse, o_rx_data has just been updated
//   o_tx_underrun          one-cycle pulse, a word went out with no data loaded
//
// Handshake: a tx word is transferred on the rising i_clk edge at which
// i_tx_valid and o_tx_ready are both high. While i_tx_valid is high and
// o_tx_ready is low the producer holds i_tx_data stable. The receive side has
// no ready: o_rx_valid fires whether or not anyone consumes it, and an unread
// o_rx_data is simply overwritten by the next word.
//
// Modports
//   slave  : the peripheral side (spi_peripheral)
//   master : the user logic that feeds and drains the peripheral
// ---------------------------------------------------------------------------
interface spi_peripheral_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_tx_data;
    logic             i_tx_valid;
    logic             o_tx_ready;
    logic [WIDTH-1:0] o_rx_data;
    logic             o_rx_valid;
    logic             o_tx_underrun;

    modport slave (
        input  i_tx_data,
        input  i_tx_valid,
        output o_tx_ready,
        output o_rx_data,
        output o_rx_valid,
        output o_tx_underrun
    );

    modport master (
        output i_tx_data,
        output i_tx_valid,
        input  o_tx_ready,
        input  o_rx_data,
        input  o_rx_valid,
        input  o_tx_underrun
    );
endinterface

// File: rtl/spi_peripheral.sv
// ---------------------------------------------------------------------------
// spi_peripheral
// SPI mode-0 peripheral (target) clocked entirely by the system clock i_clk.
// The SPI pins are oversampled: each passes a 2-flop synchronizer and SCLK /
// CS edges are detected on the synchronized copies, so i_clk must run at
// least 4x the SCLK rate. MOSI is sampled on SCLK rise, MISO changes on SCLK
// fall, MSB first. Several words may be exchanged back to back inside one
// CS-low window.
//
// Parameters
//   WIDTH          frame length in bits, 4..32
//
// Ports
//   i_clk          system clock, rising edge only
//   i_rst          synchronous active-high reset
//   i_sclk         SPI clock from the controller (asynchronous)
//   i_cs_n         SPI chip select, active low (asynchronous)
//   i_mosi         SPI data from the controller (asynchronous)
//   o_miso         SPI data to the controller
//   o_busy         high while a frame is in progress (LOAD / SHIFT)
//   o_dbg_state    current FSM state (WAIT_CS=0, IDLE=1, LOAD=2, SHIFT=3)
//   bus            spi_peripheral_if.slave: tx handshake, rx word, underrun
//
// Build option
//   SPI_PERIPHERAL_MISO_TRISTATE_EN  when defined, o_miso is high-impedance
//                  outside LOAD/SHIFT; otherwise it drives 0 there.
// ---------------------------------------------------------------------------
module spi_peripheral #(
    parameter int WIDTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    output wire         o_miso,
    output logic        o_busy,
    output logic [1:0]  o_dbg_state,
    spi_peripheral_if.slave bus
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_WAIT_CS = 2'd0,
        S_IDLE    = 2'd1,
        S_LOAD    = 2'd2,
        S_SHIFT   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // -----------------------------------------------------------------------
    // Synchronizers and edge detection
    // -----------------------------------------------------------------------
    // The CS synchronizer resets to "low" on purpose: coming out of reset the
    // peripheral must not believe CS is high until the real pin has been
    // sampled high, so a reset in the middle of a frame keeps it in WAIT_CS.
    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_d;
    logic       cs_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b00;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], i_sclk};
            cs_sync   <= {cs_sync[0],   i_cs_n};
            mosi_sync <= {mosi_sync[0], i_mosi};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall;

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise =  sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s &  sclk_d;
    assign cs_fall   = ~cs_s   &  cs_d;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_WAIT_CS;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    // SHIFT leaves on CS being high rather than strictly on its edge, so a CS
    // rise that happens to land in the single LOAD cycle still ends the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT_CS: if (cs_s)    state_nxt = S_IDLE;
            S_IDLE:    if (cs_fall) state_nxt = S_LOAD;
            S_LOAD:                 state_nxt = S_SHIFT;
            S_SHIFT:   if (cs_s)    state_nxt = S_IDLE;
            default:                state_nxt = S_WAIT_CS;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath control
    // -----------------------------------------------------------------------
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             tx_underrun;
    logic [CW-1:0]    bit_cnt;
    logic             wrapped;     // a full word was received, reload on next fall
    logic             und_pend;    // reloaded word was empty, not yet clocked

    logic in_frame;
    logic shift_active;
    logic bit_rise;
    logic bit_fall;
    logic load_pt;
    logic tx_ready;
    logic tx_hs;

    assign in_frame     = (state == S_LOAD) || (state == S_SHIFT);
    assign shift_active = (state == S_SHIFT) && !cs_s;
    assign bit_rise     = shift_active && sclk_rise;
    assign bit_fall     = shift_active && sclk_fall;
    // Load points: start of frame, and the SCLK fall after each completed word.
    assign load_pt      = (state == S_LOAD) || (bit_fall && wrapped);
    assign tx_ready     = ~hold_full;
    assign tx_hs        = bus.i_tx_valid && tx_ready;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    // The fall after the last bit of a frame is indistinguishable from the
    // fall after a mid-frame word, so it also reloads the shifter. An empty
    // reload therefore only raises und_pend; the underrun is reported when the
    // controller actually clocks the first bit of that empty word. An empty
    // load at the start of the frame is reported immediately. A word consumed
    // by any load point is gone, even if CS then rises before it is sent.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_full   <= 1'b0;
            hold_data   <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            bit_cnt     <= '0;
            wrapped     <= 1'b0;
            und_pend    <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (load_pt) begin
                wrapped <= 1'b0;
                if (hold_full) begin
                    tx_shift  <= hold_data;
                    hold_full <= 1'b0;
                end else if (bus.i_tx_valid) begin
                    // Word offered in the same cycle goes straight to the
                    // shifter; the holding register stays empty.
                    tx_shift <= bus.i_tx_data;
                end else begin
                    tx_shift <= '0;
                    if (state == S_LOAD) begin
                        tx_underrun <= 1'b1;
                    end else begin
                        und_pend <= 1'b1;
                    end
                end
            end else begin
                if (tx_hs) begin
                    hold_data <= bus.i_tx_data;
                    hold_full <= 1'b1;
                end
                if (bit_fall) begin
                    tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                end
            end

            if (bit_rise) begin
                rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                if (und_pend) begin
                    tx_underrun <= 1'b1;
                    und_pend    <= 1'b0;
                end
                if (bit_cnt == LAST_BIT) begin
                    rx_data  <= {rx_shift[WIDTH-2:0], mosi_s};
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                    wrapped  <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end

            // Outside a frame, or as CS goes high, drop any partial word.
            if (!in_frame || (state == S_SHIFT && cs_s)) begin
                rx_shift <= '0;
                bit_cnt  <= '0;
                wrapped  <= 1'b0;
                und_pend <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.o_tx_ready    = tx_ready;
    assign bus.o_rx_data     = rx_data;
    assign bus.o_rx_valid    = rx_valid;
    assign bus.o_tx_underrun = tx_underrun;
    assign o_busy            = in_frame;
    assign o_dbg_state       = state;

`ifdef SPI_PERIPHERAL_MISO_TRISTATE_EN
    assign o_miso = in_frame ? tx_shift[WIDTH-1] : 1'bz;
`else
    assign o_miso = in_frame & tx_shift[WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// ---------------------------------------------------------------------------
// tb_spi_peripheral
// Self-checking bench for spi_peripheral (WIDTH = 8). Acts as the SPI
// controller, feeds tx words over the interface, and compares the MISO bit
// stream, received words and underrun pulses against expectations derived
// from the word-level behaviour of the peripheral.
// ---------------------------------------------------------------------------
module tb_spi_peripheral;

    localparam int W    = 8;
    localparam int HALF = 6;   // i_clk cycles per SCLK half period

`ifdef SPI_PERIPHERAL_MISO_TRISTATE_EN
    localparam logic IDLE_MISO = 1'bz;
`else
    localparam logic IDLE_MISO = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    wire        miso;
    logic       busy;
    logic [1:0] dbg_state;

    spi_peripheral_if #(.WIDTH(W)) bus ();

    spi_peripheral #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sclk      (sclk),
        .i_cs_n      (cs_n),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .o_busy      (busy),
        .o_dbg_state (dbg_state),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_err    = 0;
    int         n_rx     = 0;
    int         n_und    = 0;
    logic [W-1:0] obs_q[$];
    logic [W-1:0] exp_q[$];
    logic       busy_acc;

    // Monitor: records every rx word and counts underrun pulses.
    always @(negedge clk) begin
        if (bus.o_rx_valid) begin
            obs_q.push_back(bus.o_rx_data);
            n_rx++;
        end
        if (bus.o_tx_underrun) n_und++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drain_rx(input string name);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL %s: rx word missing, expected 0x%0h", name, e);
            end else begin
                check(name, 32'(obs_q.pop_front()), 32'(e));
            end
        end
        while (obs_q.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: unexpected rx word 0x%0h", name, obs_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            busy_acc = busy_acc | busy;
        end
    endtask

    task automatic push_tx(input logic [W-1:0] d);
        int t = 0;
        while (bus.o_tx_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_bit("tx_ready_wait", bus.o_tx_ready, 1'b1);
        if (bus.o_tx_ready === 1'b1) begin
            bus.i_tx_data  = d;
            bus.i_tx_valid = 1'b1;
            @(negedge clk);
            bus.i_tx_valid = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_cyc(8);
    endtask

    task automatic cs_high();
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(10);
    endtask

    // Clocks nbits with MOSI taken MSB-first from mosi_v; MISO is captured
    // just before each rising SCLK, as the controller would sample it.
    task automatic xfer(input int nbits, input logic [31:0] mosi_v, output logic [31:0] miso_v);
        miso_v = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mosi_v[nbits-1-i];
            wait_cyc(HALF);
            miso_v[nbits-1-i] = miso;
            sclk = 1'b1;
            wait_cyc(HALF);
            sclk = 1'b0;
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [W-1:0] tx;
        bit           load;
        logic [W-1:0] mosi_w;
        logic [W-1:0] exp_miso;
        int           exp_und;
    } vec_t;

    vec_t vecs[5];

    // ---------------- randomized frames vs word-level model ----------------
    // Model: the controller sees the loaded words back to back, MSB first; a
    // frame whose only word was never loaded shows all zeros and one
    // underrun; every complete MOSI word is received exactly once.
    task automatic random_frames(input int n);
        logic [W-1:0] txw[3];
        logic [W-1:0] rxw[3];
        logic [31:0]  mosi_v, miso_v, exp_m;
        int           nw, rx0, u0, exp_und;
        bit           loaded;
        for (int f = 0; f < n; f++) begin
            nw     = $urandom_range(1, 3);
            loaded = !(nw == 1 && $urandom_range(0, 3) == 0);
            mosi_v = '0;
            exp_m  = '0;
            for (int k = 0; k < nw; k++) begin
                txw[k] = W'($urandom);
                rxw[k] = W'($urandom);
                mosi_v = (mosi_v << W) | 32'(rxw[k]);
                exp_m  = (exp_m  << W) | (loaded ? 32'(txw[k]) : 32'd0);
                exp_q.push_back(rxw[k]);
            end
            exp_und = loaded ? 0 : 1;
            rx0 = n_rx;
            u0  = n_und;
            fork
                begin
                    if (loaded) for (int k = 0; k < nw; k++) push_tx(txw[k]);
                end
                begin
                    wait_cyc(2);
                    cs_low();
                    xfer(nw * W, mosi_v, miso_v);
                    cs_high();
                end
            join
            check("rand_miso", miso_v, exp_m);
            check("rand_rxcount", 32'(n_rx - rx0), 32'(nw));
            check("rand_underrun", 32'(n_und - u0), 32'(exp_und));
            drain_rx("rand_rx");
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] mv;
        int rx0, u0;

        rst            = 1'b1;
        sclk           = 1'b0;
        cs_n           = 1'b1;
        mosi           = 1'b0;
        busy_acc       = 1'b0;
        bus.i_tx_data  = '0;
        bus.i_tx_valid = 1'b0;

        vecs[0] = '{tx: 8'hA5, load: 1'b1, mosi_w: 8'h3C, exp_miso: 8'hA5, exp_und: 0};
        vecs[1] = '{tx: 8'h00, load: 1'b0, mosi_w: 8'h5A, exp_miso: 8'h00, exp_und: 1};
        vecs[2] = '{tx: 8'hFF, load: 1'b1, mosi_w: 8'h00, exp_miso: 8'hFF, exp_und: 0};
        vecs[3] = '{tx: 8'h01, load: 1'b1, mosi_w: 8'h81, exp_miso: 8'h01, exp_und: 0};
        vecs[4] = '{tx: 8'h6B, load: 1'b1, mosi_w: 8'hC7, exp_miso: 8'h6B, exp_und: 0};

        // Reset state
        repeat (3) @(negedge clk);
        check_bit("reset_tx_ready", bus.o_tx_ready, 1'b1);
        check_bit("reset_rx_valid", bus.o_rx_valid, 1'b0);
        check_bit("reset_underrun", bus.o_tx_underrun, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check("reset_rx_data", 32'(bus.o_rx_data), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        check_bit("reset_miso", miso, IDLE_MISO);
        rst = 1'b0;
        wait_cyc(10);
        check("idle_state", 32'(dbg_state), 32'd1);
        check_bit("idle_miso", miso, IDLE_MISO);

        // Single-word frames from the table
        for (int i = 0; i < 5; i++) begin
            rx0 = n_rx;
            u0  = n_und;
            if (vecs[i].load) push_tx(vecs[i].tx);
            exp_q.push_back(vecs[i].mosi_w);
            cs_low();
            check_bit("vec_busy", busy, 1'b1);
            xfer(W, 32'(vecs[i].mosi_w), mv);
            cs_high();
            check("vec_miso", mv, 32'(vecs[i].exp_miso));
            check("vec_rxcount", 32'(n_rx - rx0), 32'd1);
            check("vec_underrun", 32'(n_und - u0), 32'(vecs[i].exp_und));
            drain_rx("vec_rx");
            check_bit("vec_idle_miso", miso, IDLE_MISO);
            check_bit("vec_idle_busy", busy, 1'b0);
        end

        // Two words back to back in one CS window
        rx0 = n_rx;
        u0  = n_und;
        push_tx(8'h11);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h5E);
        fork
            push_tx(8'h22);
            begin
                cs_low();
                xfer(2 * W, 32'h0000_C35E, mv);
                cs_high();
            end
        join
        check("b2b_miso", mv, 32'h0000_1122);
        check("b2b_rxcount", 32'(n_rx - rx0), 32'd2);
        check("b2b_underrun", 32'(n_und - u0), 32'd0);
        drain_rx("b2b_rx");

        // CS rises after 5 bits: nothing received, next frame is clean
        rx0 = n_rx;
        push_tx(8'h77);
        cs_low();
        xfer(5, 32'h0000_0015, mv);
        cs_high();
        check("abort_rxcount", 32'(n_rx - rx0), 32'd0);
        push_tx(8'h5A);
        exp_q.push_back(8'h81);
        cs_low();
        xfer(W, 32'h0000_0081, mv);
        cs_high();
        check("abort_next_miso", mv, 32'h0000_005A);
        check("abort_next_rxcount", 32'(n_rx - rx0), 32'd1);
        drain_rx("abort_next_rx");

        // Reset with CS low mid-frame: bus ignored until CS goes high again
        rx0 = n_rx;
        u0  = n_und;
        push_tx(8'hC3);
        cs_low();
        xfer(3, 32'h0000_0005, mv);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(4);
        busy_acc = 1'b0;
        xfer(3, 32'h0000_0005, mv);
        wait_cyc(4);
        check_bit("rst_mid_busy", busy_acc, 1'b0);
        check("rst_mid_state", 32'(dbg_state), 32'd0);
        check("rst_mid_rxcount", 32'(n_rx - rx0), 32'd0);
        check("rst_mid_underrun", 32'(n_und - u0), 32'd0);
        check_bit("rst_mid_miso", miso, IDLE_MISO);
        cs_high();
        check("rst_mid_idle_state", 32'(dbg_state), 32'd1);
        push_tx(8'h96);
        exp_q.push_back(8'h69);
        cs_low();
        xfer(W, 32'h0000_0069, mv);
        cs_high();
        check("rst_after_miso", mv, 32'h0000_0096);
        check("rst_after_rxcount", 32'(n_rx - rx0), 32'd1);
        drain_rx("rst_after_rx");

        // Randomized frames
        random_frames(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter WIDTH, default 8, meaning frame length in bits; SHALL be supported for 4..32.
REQ-002 i_clk  input  1  system clock; SHALL be the only clock; all logic SHALL be rising-edge.
REQ-003 i_rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 i_sclk, i_cs_n, i_mosi  input  1 each  external SPI bus, asynchronous to i_clk.
REQ-005 o_miso  output  1  serial data to controller.
REQ-006 i_tx_data  input  WIDTH  next word to transmit.
REQ-007 i_tx_valid  input  1  i_tx_data valid.
REQ-008 o_tx_ready  output  1  holding register empty.
REQ-009 o_rx_data  output  WIDTH  last received word.
REQ-010 o_rx_valid  output  1  one-cycle pulse, o_rx_data new.
REQ-011 o_tx_underrun  output  1  one-cycle pulse, word sent with no data loaded.
REQ-012 o_busy  output  1  high while a frame is in progress (CS low, synchronized).

Function
REQ-013 i_sclk, i_cs_n and i_mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized sclk/cs_n; i_clk SHALL be at least 4x SCLK.
REQ-014 SPI mode 0: MOSI sampled on detected SCLK rise; o_miso updated on detected SCLK fall; MSB first.
REQ-015 FSM states: WAIT_CS (CS low seen out of reset), IDLE, LOAD, SHIFT.
REQ-016 IDLE -> LOAD on CS falling edge; LOAD -> SHIFT after exactly one cycle; SHIFT -> IDLE on CS rising edge; WAIT_CS -> IDLE once synchronized CS is high.
REQ-017 Tx handshake: holding register loads i_tx_data when i_tx_valid && o_tx_ready; o_tx_ready SHALL deassert the cycle after the transfer.
REQ-018 LOAD SHALL move holding register into tx shifter and drive its MSB on o_miso; holding register then frees (o_tx_ready high next cycle).
REQ-019 If holding register empty at a load point, shifter SHALL load all-zeros and o_tx_underrun SHALL pulse one cycle.
REQ-020 Bit counter counts SCLK rises 0..WIDTH-1; at the WIDTH-th rise, o_rx_data SHALL update and o_rx_valid SHALL pulse in the same cycle; counter wraps to 0.
REQ-021 On the SCLK fall following a wrap, shifter SHALL reload from holding register (REQ-018/019 rules) for back-to-back words within one CS-low window.
REQ-022 Simultaneous tx handshake and load point: the load SHALL take the new word (bypass), o_tx_ready stays high.
REQ-023 CS rising mid-word: partial bits discarded, no o_rx_valid, counter cleared, consumed tx word not re-sent.
REQ-024 o_rx_valid SHALL fire regardless of consumer; an unread o_rx_data is overwritten (no backpressure).
REQ-025 o_busy SHALL be high in LOAD and SHIFT, low otherwise.

Reset
REQ-026 On i_rst: state WAIT_CS, counter 0, shifters 0, holding register empty, o_tx_ready 1, o_rx_data 0, o_rx_valid 0, o_tx_underrun 0, o_busy 0, o_miso per REQ-028/029.
REQ-027 Reset mid-frame SHALL abort the frame and ignore the bus until CS has been seen high.

Configuration
REQ-028 Macro SPI_PERIPHERAL_MISO_TRISTATE_EN defined: o_miso SHALL be high-impedance whenever state is not LOAD/SHIFT (including reset).
REQ-029 Macro undefined: o_miso SHALL drive 0 whenever state is not LOAD/SHIFT; no tri-state logic synthesized.

Verification
REQ-030 Load 0xA5, CS low, 8 SCLK cycles with MOSI=0x3C -> MISO bits 1,0,1,0,0,1,0,1; o_rx_data=0x3C with one o_rx_valid pulse.
REQ-031 Load 0x11 then 0x22, 16 SCLK in one CS window -> MISO 0x11 then 0x22; two rx pulses; no underrun.
REQ-032 Empty holding register, CS low, 8 SCLK -> MISO 0x00, one o_tx_underrun pulse.
REQ-033 CS high after 5 SCLK -> no o_rx_valid; next full frame receives MOSI 0x81 correctly.
REQ-034 Assert i_rst with CS low mid-frame, release, clock 3 SCLK -> no activity until CS toggles high then low.
REQ-035 Idle CS high -> o_miso = Z with SPI_PERIPHERAL_MISO_TRISTATE_EN, 0 without.
